// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int FETCH_XLEN = 32;

  // All-zero word decodes as opcode 7'b0000000, which decode treats as a bubble.
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  localparam logic [FETCH_XLEN-1:0] DEFAULT_RESET_PC = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DROP
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: flush > stall > load > bubble, async active-low reset.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int XLEN = FETCH_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            stall,
  input  logic            load,
  input  logic [31:0]     instr_in,
  input  logic [XLEN-1:0] pc_in,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            valid
);

  // Priority update of the decode-facing register; reset and flush both give a bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instr    <= BUBBLE_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (flush) begin
      instr    <= BUBBLE_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (stall) begin
      instr    <= instr;
      pc       <= pc;
      pc_plus4 <= pc_plus4;
      valid    <= valid;
    end else if (load) begin
      instr    <= instr_in;
      pc       <= pc_in;
      pc_plus4 <= pc_in + XLEN'(4);
      valid    <= 1'b1;
    end else begin
      instr    <= BUBBLE_INSTR;
      pc       <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, runs a single-outstanding imem request FSM,
// and feeds the IF/ID register.
//
// Handshake: a request transfers on a cycle where imem_req && imem_gnt; imem_addr
// stays stable while imem_req is high and not granted. Exactly one imem_rvalid
// follows each grant, at least one cycle later, carrying imem_rdata.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output fetch_state_e    dbg_state
);

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pcf, pcf_nxt;
  logic [XLEN-1:0] pc_pend, pc_pend_nxt;
  logic [31:0]     hold_instr, hold_nxt;
  logic            deliver;
  logic [31:0]     deliver_instr;
  logic [XLEN-1:0] target;

  assign target    = PCTargetE & ~(XLEN'(3));
  assign imem_req  = (state == S_REQ);
  assign imem_addr = pcf;
  assign dbg_state = state;

  // State, PC, pending-PC and hold-buffer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      pcf        <= RESET_PC;
      pc_pend    <= '0;
      hold_instr <= BUBBLE_INSTR;
    end else begin
      state      <= state_nxt;
      pcf        <= pcf_nxt;
      pc_pend    <= pc_pend_nxt;
      hold_instr <= hold_nxt;
    end
  end

  // Next-state logic; a redirect always wins and discards queued or in-flight work.
  always_comb begin
    state_nxt     = state;
    pcf_nxt       = pcf;
    pc_pend_nxt   = pc_pend;
    hold_nxt      = hold_instr;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        if (PCSrcE) begin
          pcf_nxt   = target;
          // A grant this cycle means a response for the old PC is coming.
          state_nxt = imem_gnt ? S_DROP : S_REQ;
        end else if (imem_gnt) begin
          pc_pend_nxt = pcf;
          pcf_nxt     = pcf + XLEN'(4);
          state_nxt   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (PCSrcE) begin
          pcf_nxt   = target;
          state_nxt = imem_rvalid ? S_REQ : S_DROP;
        end else if (imem_rvalid) begin
          if (!StallD && !FlushD) begin
            deliver   = 1'b1;
            state_nxt = S_REQ;
          end else begin
            hold_nxt  = imem_rdata;
            state_nxt = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (PCSrcE) begin
          pcf_nxt   = target;
          state_nxt = S_REQ;
        end else if (!StallD && !FlushD) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          state_nxt     = S_REQ;
        end
      end
      S_DROP: begin
        if (PCSrcE) pcf_nxt = target;
        // The stale response is consumed even if a further redirect lands with it,
        // otherwise the FSM would wait for a response that never comes.
        if (imem_rvalid) state_nxt = S_REQ;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  if_id_reg #(.XLEN(XLEN)) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .flush    (FlushD),
    .stall    (StallD),
    .load     (deliver),
    .instr_in (deliver_instr),
    .pc_in    (pc_pend),
    .instr    (InstrD),
    .pc       (PCD),
    .pc_plus4 (PCPlus4D),
    .valid    (ValidD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage; imem handshakes are driven cycle by cycle.
module tb_fetch_stage;
  import fetch_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         StallD, FlushD, PCSrcE;
  logic [31:0]  PCTargetE;
  logic         imem_req;
  logic [31:0]  imem_addr;
  logic         imem_gnt, imem_rvalid;
  logic [31:0]  imem_rdata;
  logic [31:0]  InstrD, PCD, PCPlus4D;
  logic         ValidD;
  fetch_state_e dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  fetch_stage dut (
    .clk         (clk),
    .reset       (reset),
    .StallD      (StallD),
    .FlushD      (FlushD),
    .PCSrcE      (PCSrcE),
    .PCTargetE   (PCTargetE),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .InstrD      (InstrD),
    .PCD         (PCD),
    .PCPlus4D    (PCPlus4D),
    .ValidD      (ValidD),
    .dbg_state   (dbg_state)
  );

  // Clock generation
  always #5 clk = ~clk;

  // Watchdog so the run always ends
  initial begin
    #200000;
    tests_failed++;
    $display("FAIL watchdog: got timeout want completion");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    StallD = 0; FlushD = 0; PCSrcE = 0; PCTargetE = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    step();
    step();
    reset = 1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 0;
    step();
    step();
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== 97'h0) begin tests_failed++; $display("FAIL reset_ifid: got %h want 0", {ValidD, PCD, PCPlus4D, InstrD}); end
    tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req: got %b want 0", imem_req); end
    tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_addr: got %h want 0", imem_addr); end
    tests_run++; if (dbg_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", dbg_state, S_IDLE); end
    reset = 1;
    step();
    tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL reset_first_req: got %b want 1", imem_req); end
  endtask

  task automatic test_stream();
    logic [31:0] words [3];
    words[0] = 32'h0000_0013; words[1] = 32'h0010_0093; words[2] = 32'h0020_0113;
    do_reset();
    imem_gnt = 1;
    step();
    for (int i = 0; i < 3; i++) begin
      tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'(i * 4)}) begin tests_failed++; $display("FAIL stream_req%0d: got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(i * 4)); end
      step();
      tests_run++; if ({imem_req, ValidD} !== 2'b00) begin tests_failed++; $display("FAIL stream_wait%0d: got req %b valid %b want 0 0", i, imem_req, ValidD); end
      imem_rvalid = 1; imem_rdata = words[i];
      step();
      imem_rvalid = 0; imem_rdata = '0;
      tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'(i * 4), 32'(i * 4 + 4), words[i]}) begin tests_failed++; $display("FAIL stream_ifid%0d: got %b %h %h %h want 1 %h %h %h", i, ValidD, PCD, PCPlus4D, InstrD, 32'(i * 4), 32'(i * 4 + 4), words[i]); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    imem_gnt = 1;
    step();
    for (int i = 0; i < 2; i++) begin
      step();
      imem_rvalid = 1; imem_rdata = 32'h0000_1000 + 32'(i);
      step();
      imem_rvalid = 0;
    end
    // IF/ID now holds the PC 4 word; stall starts in the PC 8 request cycle.
    StallD = 1;
    step();
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h4, 32'h8, 32'h0000_1001}) begin tests_failed++; $display("FAIL stall_hold1: got %b %h %h %h want 1 4 8 00001001", ValidD, PCD, PCPlus4D, InstrD); end
    imem_rvalid = 1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 0; imem_rdata = '0;
    tests_run++; if ({imem_req, ValidD, PCD} !== {1'b0, 1'b1, 32'h4}) begin tests_failed++; $display("FAIL stall_hold2: got req %b valid %b pc %h want 0 1 4", imem_req, ValidD, PCD); end
    step();
    tests_run++; if ({imem_req, ValidD, PCD} !== {1'b0, 1'b1, 32'h4}) begin tests_failed++; $display("FAIL stall_hold3: got req %b valid %b pc %h want 0 1 4", imem_req, ValidD, PCD); end
    StallD = 0;
    step();
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h8, 32'hC, 32'h0050_0093}) begin tests_failed++; $display("FAIL stall_release: got %b %h %h %h want 1 8 c 00500093", ValidD, PCD, PCPlus4D, InstrD); end
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'hC}) begin tests_failed++; $display("FAIL stall_next_req: got %b/%h want 1/c", imem_req, imem_addr); end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    imem_gnt = 1;
    step();
    step();
    imem_gnt = 0; PCSrcE = 1; PCTargetE = 32'h103; FlushD = 1;
    step();
    PCSrcE = 0; PCTargetE = '0; FlushD = 0;
    tests_run++; if ({imem_req, ValidD} !== 2'b00) begin tests_failed++; $display("FAIL redir_wait_drop: got req %b valid %b want 0 0", imem_req, ValidD); end
    step();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rvalid = 0; imem_rdata = '0;
    tests_run++; if ({imem_req, imem_addr, ValidD, InstrD} !== {1'b1, 32'h100, 1'b0, 32'h0}) begin tests_failed++; $display("FAIL redir_wait_discard: got req %b addr %h valid %b instr %h want 1 100 0 0", imem_req, imem_addr, ValidD, InstrD); end
    imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h00A0_0513;
    step();
    imem_rvalid = 0;
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h100, 32'h104, 32'h00A0_0513}) begin tests_failed++; $display("FAIL redir_wait_target: got %b %h %h %h want 1 100 104 00a00513", ValidD, PCD, PCPlus4D, InstrD); end
  endtask

  task automatic test_redirect_gnt_hold();
    do_reset();
    imem_gnt = 1;
    step();
    PCSrcE = 1; PCTargetE = 32'h200; FlushD = 1;
    step();
    PCSrcE = 0; FlushD = 0; imem_gnt = 0;
    tests_run++; if ({imem_req, dbg_state} !== {1'b0, S_DROP}) begin tests_failed++; $display("FAIL redir_gnt_drop: got req %b state %0d want 0 %0d", imem_req, dbg_state, S_DROP); end
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    step();
    imem_rvalid = 0;
    tests_run++; if ({imem_req, imem_addr, ValidD} !== {1'b1, 32'h200, 1'b0}) begin tests_failed++; $display("FAIL redir_gnt_discard: got req %b addr %h valid %b want 1 200 0", imem_req, imem_addr, ValidD); end
    imem_gnt = 1;
    step();
    imem_rvalid = 1; imem_rdata = 32'h0010_0193;
    step();
    imem_rvalid = 0;
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h200, 32'h204, 32'h0010_0193}) begin tests_failed++; $display("FAIL redir_gnt_target: got %b %h %h %h want 1 200 204 00100193", ValidD, PCD, PCPlus4D, InstrD); end
    step();
    StallD = 1; imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 0;
    tests_run++; if (dbg_state !== S_HOLD) begin tests_failed++; $display("FAIL hold_entry: got %0d want %0d", dbg_state, S_HOLD); end
    StallD = 0; PCSrcE = 1; PCTargetE = 32'h300; FlushD = 1;
    step();
    PCSrcE = 0; FlushD = 0;
    tests_run++; if ({imem_req, imem_addr, ValidD, InstrD} !== {1'b1, 32'h300, 1'b0, 32'h0}) begin tests_failed++; $display("FAIL hold_redirect: got req %b addr %h valid %b instr %h want 1 300 0 0", imem_req, imem_addr, ValidD, InstrD); end
    step();
    step();
    tests_run++; if ({ValidD, InstrD} !== {1'b0, 32'h0}) begin tests_failed++; $display("FAIL hold_dropped: got valid %b instr %h want 0 0", ValidD, InstrD); end
    imem_gnt = 1;
    step();
    imem_gnt = 0; imem_rvalid = 1; imem_rdata = 32'h0020_0213;
    step();
    imem_rvalid = 0;
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== {1'b1, 32'h300, 32'h304, 32'h0020_0213}) begin tests_failed++; $display("FAIL hold_target: got %b %h %h %h want 1 300 304 00200213", ValidD, PCD, PCPlus4D, InstrD); end
  endtask

  task automatic test_gnt_low();
    do_reset();
    step();
    for (int i = 0; i < 5; i++) begin
      tests_run++; if ({imem_req, imem_addr, ValidD} !== {1'b1, 32'h0, 1'b0}) begin tests_failed++; $display("FAIL gnt_low%0d: got req %b addr %h valid %b want 1 0 0", i, imem_req, imem_addr, ValidD); end
      step();
    end
    imem_gnt = 1;
    step();
    imem_gnt = 0;
    tests_run++; if ({imem_req, imem_addr} !== {1'b0, 32'h4}) begin tests_failed++; $display("FAIL gnt_low_accept: got %b/%h want 0/4", imem_req, imem_addr); end
  endtask

  task automatic test_async_reset();
    do_reset();
    imem_gnt = 1;
    step();
    step();
    imem_rvalid = 1; imem_rdata = 32'h0030_0293;
    step();
    imem_rvalid = 0;
    StallD = 1;
    step();
    tests_run++; if ({dbg_state, ValidD} !== {S_WAIT, 1'b1}) begin tests_failed++; $display("FAIL areset_pre: got state %0d valid %b want %0d 1", dbg_state, ValidD, S_WAIT); end
    #2 reset = 0;
    #1;
    tests_run++; if ({ValidD, PCD, PCPlus4D, InstrD} !== 97'h0) begin tests_failed++; $display("FAIL areset_ifid: got %h want 0", {ValidD, PCD, PCPlus4D, InstrD}); end
    tests_run++; if ({imem_req, imem_addr, dbg_state} !== {1'b0, 32'h0, S_IDLE}) begin tests_failed++; $display("FAIL areset_fsm: got req %b addr %h state %0d want 0 0 %0d", imem_req, imem_addr, dbg_state, S_IDLE); end
    clear_inputs();
    step();
    reset = 1;
    step();
    tests_run++; if ({imem_req, imem_addr} !== {1'b1, 32'h0}) begin tests_failed++; $display("FAIL areset_restart: got %b/%h want 1/0", imem_req, imem_addr); end
  endtask

  // Test sequence and final report
  initial begin
    reset = 0;
    clear_inputs();
    test_reset();
    test_stream();
    test_stall();
    test_redirect_wait();
    test_redirect_gnt_hold();
    test_gnt_low();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
